// File: rtl/tail_aligner.sv
// Variable-length instruction aligner: buffers fetch words in a 2N-parcel ring
// and emits one instruction per handshake, with its length decoded externally.
module tail_aligner #(
  parameter int W    = 4,
  parameter int N    = 16,
  parameter int LMAX = 7,
  parameter int LW   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [$clog2(N)-1:0]        flush_off,
  input  logic [W*N-1:0]              in_word,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [W-1:0]                hd_par,
  input  logic [LW-1:0]               hd_len,
  output logic [W*LMAX-1:0]           out_ins,
  output logic [LW-1:0]               out_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(2*N):0]        level
);

  localparam int PW = $clog2(N);
  localparam int AW = $clog2(2*N);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] skip_q, skip_d;
  logic [W-1:0]  buf_q [2*N];
  logic [W-1:0]  buf_d [2*N];
  logic [W-1:0]  in_par [N];
  logic [LW-1:0] len_eff;
  logic [AW-1:0] wr;
  logic          acc;
  logic          emit;

  always_comb begin
    len_eff = hd_len;
    if (hd_len == '0)
      len_eff = LW'(1);
    else if (hd_len > LW'(LMAX))
      len_eff = LW'(LMAX);
  end

  assign in_ready  = !flush && (cnt_q <= CW'(N));
  assign out_valid = !flush && (cnt_q >= CW'(len_eff));
  assign out_len   = len_eff;
  assign level     = cnt_q;
  assign hd_par    = buf_q[rd_q];
  assign acc       = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign wr        = rd_q + cnt_q[AW-1:0];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign in_par[gi] = in_word[gi*W +: W];
  end

  for (genvar gi = 0; gi < LMAX; gi++) begin : g_out
    logic [AW-1:0] pos;
    assign pos = rd_q + AW'(gi);
    assign out_ins[gi*W +: W] = (LW'(gi) < len_eff) ? buf_q[pos] : '0;
  end

  // Each ring slot decides whether it lies in the free window receiving the
  // incoming word; cnt <= N guarantees the window never reaches live data.
  for (genvar gi = 0; gi < 2*N; gi++) begin : g_wr
    logic [AW-1:0] off;
    logic [PW-1:0] src;
    logic          we;
    assign off = AW'(gi) - wr;
    assign src = off[PW-1:0] + skip_q;
    assign we  = acc && (CW'(off) < (CW'(N) - CW'(skip_q)));
    always_comb begin
      buf_d[gi] = buf_q[gi];
      if (we)
        buf_d[gi] = in_par[src];
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    skip_d = skip_q;
    if (flush) begin
      cnt_d  = '0;
      skip_d = flush_off;
    end else begin
      if (acc) begin
        cnt_d  = cnt_d + (CW'(N) - CW'(skip_q));
        skip_d = '0;
      end
      if (emit) begin
        cnt_d = cnt_d - CW'(len_eff);
        rd_d  = rd_q + AW'(len_eff);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      cnt_q  <= '0;
      skip_q <= '0;
    end else begin
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
    end
  end

endmodule
